cmd_frame_tx: RTL

//  Command-frame transmitter; the sending-side counterpart of the RS422 command decoder.
//  On a one-hot command request it emits the byte sequence EB 90 04 <type> <payload...> <csum>
//  to the UART byte transmitter over a valid/ready handshake.

---
 rtl/cmd_frame_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cmd_frame_tx.sv
// Command-frame transmitter: EB 90 04 <type> <payload...> <csum> over a valid/ready byte port.
// First byte 1 cycle after an accepted request; tx_data held while stalled; payload costs 2 cycles/byte.
module cmd_frame_tx #(
  parameter logic [7:0] HDR0   = 8'hEB,
  parameter logic [7:0] HDR1   = 8'h90,
  parameter logic [7:0] HDR2   = 8'h04,
  parameter int         MAX_PL = 16,
  parameter int         AW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    cmd_req,
  input  logic [4:0]    pl_len,
  output logic          pl_rd_en,
  output logic [AW-1:0] pl_rd_addr,
  input  logic [7:0]    pl_rd_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_TYPE, S_FETCH, S_PL, S_CSUM, S_DONE
  } state_t;

  localparam logic [4:0] MAX_LEN = 5'(MAX_PL);

  state_t     state, state_nx;
  logic [1:0] hdr_idx;
  logic [7:0] type_q, csum, pl_byte, req_type;
  logic [4:0] rem;
  logic       pl_held, req_any, req_onehot, req_ok, xfer;

  assign req_any    = |cmd_req;
  assign req_onehot = req_any && ((cmd_req & (cmd_req - 5'd1)) == 5'd0);
  assign req_ok     = (state == S_IDLE) && req_onehot;
  assign xfer       = tx_valid && tx_ready;

  always_comb begin
    req_type = 8'h00;
    if      (cmd_req[4]) req_type = 8'h63;
    else if (cmd_req[3]) req_type = 8'h87;
    else if (cmd_req[2]) req_type = 8'h94;
    else if (cmd_req[1]) req_type = 8'h25;
    else if (cmd_req[0]) req_type = 8'h13;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req_ok) state_nx = S_HDR;
      S_HDR:   if (xfer && hdr_idx == 2'd2) state_nx = S_TYPE;
      S_TYPE:  if (xfer) state_nx = (rem != 5'd0) ? S_FETCH : S_CSUM;
      S_FETCH: state_nx = S_PL;
      S_PL:    if (xfer) state_nx = (rem > 5'd1) ? S_FETCH : S_CSUM;
      S_CSUM:  if (xfer) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    pl_rd_en = 1'b0;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    unique case (state)
      S_HDR: begin
        tx_valid = 1'b1;
        case (hdr_idx)
          2'd0:    tx_data = HDR0;
          2'd1:    tx_data = HDR1;
          default: tx_data = HDR2;
        endcase
      end
      S_TYPE: begin
        tx_valid = 1'b1;
        tx_data  = type_q;
      end
      S_FETCH: pl_rd_en = 1'b1;
      // Buffer data is only guaranteed on the first PL cycle; later stalled cycles replay the captured copy.
      S_PL: begin
        tx_valid = 1'b1;
        tx_data  = pl_held ? pl_byte : pl_rd_data;
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_idx    <= 2'd0;
      type_q     <= 8'h00;
      csum       <= 8'h00;
      pl_byte    <= 8'h00;
      pl_held    <= 1'b0;
      rem        <= 5'd0;
      pl_rd_addr <= '0;
      err        <= 1'b0;
    end else begin
      err <= (state == S_IDLE) ? (req_any && !req_onehot) : req_any;
      unique case (state)
        S_IDLE: if (req_ok) begin
          type_q     <= req_type;
          rem        <= (pl_len > MAX_LEN) ? MAX_LEN : pl_len;
          csum       <= 8'h00;
          hdr_idx    <= 2'd0;
          pl_rd_addr <= '0;
        end
        S_HDR:   if (xfer) hdr_idx <= hdr_idx + 2'd1;
        S_TYPE:  if (xfer) csum <= csum + type_q;
        S_FETCH: pl_held <= 1'b0;
        S_PL: begin
          if (!pl_held) begin
            pl_byte <= pl_rd_data;
            pl_held <= 1'b1;
          end
          if (xfer) begin
            csum       <= csum + tx_data;
            pl_rd_addr <= pl_rd_addr + {{(AW-1){1'b0}}, 1'b1};
            rem        <= rem - 5'd1;
            pl_held    <= 1'b0;
          end
        end
        S_DONE: begin
          pl_rd_addr <= '0;
          hdr_idx    <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
